// File: rtl/uart_tx_fifo.sv
// Byte-wide UART transmitter fed by a circular FIFO; 8N1 framing at CLKS_PER_BIT clocks per bit.
// Define UART_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wvalid,
    input  logic [7:0]         i_wdata,
    output logic               o_wready,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_overflow,
    output logic [FIFO_AW:0]   o_level
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [FIFO_AW:0]  LVL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]  PTR_ONE  = (FIFO_AW + 1)'(1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wptr, rptr, level;
    logic             full, do_wr, do_pop, bit_end;
    logic [7:0]       head;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
`ifdef UART_PARITY_EN
    logic             par;
`endif

    // Extra pointer bit distinguishes full from empty; subtraction wraps naturally.
    assign level   = wptr - rptr;
    assign full    = (level == LVL_FULL);
    assign head    = mem[rptr[FIFO_AW-1:0]];
    assign bit_end = (cnt == CNT_LAST);
    // Full check uses the pre-pop level, so a write colliding with a pop on a full FIFO drops.
    assign do_wr   = i_wvalid && !full && !i_rst;
    assign do_pop  = (level != '0) && ((state == IDLE) || ((state == STOP) && bit_end));

    assign o_level  = level;
    assign o_wready = !full;
    assign o_busy   = (state != IDLE) || (level != '0);

    always_ff @(posedge i_clk) begin
        if (do_wr)
            mem[wptr[FIFO_AW-1:0]] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr       <= '0;
            rptr       <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (do_wr)
                wptr <= wptr + PTR_ONE;
            if (do_pop)
                rptr <= rptr + PTR_ONE;
            if (i_wvalid && full)
                o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            o_tx  <= 1'b1;
`ifdef UART_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (do_pop) begin
                        shreg <= head;
`ifdef UART_PARITY_EN
                        par   <= ^head;
`endif
                        o_tx  <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        idx   <= '0;
                        o_tx  <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            o_tx  <= par;
                            state <= PARITY;
`else
                            o_tx  <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            o_tx  <= shreg[0];
                            shreg <= shreg >> 1;
                            idx   <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        o_tx  <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        // Chain the next frame with no idle gap when data is waiting.
                        if (do_pop) begin
                            shreg <= head;
`ifdef UART_PARITY_EN
                            par   <= ^head;
`endif
                            o_tx  <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    o_tx  <= 1'b1;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: framing, burst fill, overflow, mid-frame reset, level tracking.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * CPB;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_wvalid;
    logic [7:0]  i_wdata;
    logic        o_wready, o_tx, o_busy, o_overflow;
    logic [AW:0] o_level;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wvalid(i_wvalid), .i_wdata(i_wdata),
        .o_wready(o_wready), .o_tx(o_tx), .o_busy(o_busy),
        .o_overflow(o_overflow), .o_level(o_level)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit k of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Checks frame cycles first..last; cycle 0 is the first clock after the popping edge.
    task automatic frame(input logic [7:0] b, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            tick();
            chk($sformatf("tx_b%02h_c%0d", b, i), 32'(o_tx), 32'(exp_bit(b, i / CPB)));
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_wvalid = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    // Writes 0x00..0x10 back to back; first byte is popped one edge later.
    task automatic burst17();
        for (int n = 0; n < 17; n++) begin
            i_wvalid = 1'b1;
            i_wdata  = 8'(n);
            tick();
            chk($sformatf("burst_tx_%0d", n), 32'(o_tx), (n == 0) ? 32'd1 : 32'd0);
        end
        i_wvalid = 1'b0;
        chk("burst_level", 32'(o_level), 32'd16);
        chk("burst_wready", 32'(o_wready), 32'd0);
        chk("burst_ovf", 32'(o_overflow), 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] cur;
        logic       pop, wr;
        int         rem, nw;

        i_rst = 1'b1;
        i_wvalid = 1'b0;
        i_wdata = 8'h00;
        tick();
        tick();
        i_rst = 1'b0;

        chk("rst_tx", 32'(o_tx), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_wready", 32'(o_wready), 32'd1);

        // Single byte 0x40 from idle.
        i_wvalid = 1'b1;
        i_wdata  = 8'h40;
        tick();
        i_wvalid = 1'b0;
        chk("t1_level", 32'(o_level), 32'd1);
        chk("t1_busy", 32'(o_busy), 32'd1);
        chk("t1_tx_idle", 32'(o_tx), 32'd1);
        frame(8'h40, 0, FL - 1);
        chk("t1_busy_last_stop", 32'(o_busy), 32'd1);
        tick();
        chk("t1_busy_done", 32'(o_busy), 32'd0);
        chk("t1_tx_done", 32'(o_tx), 32'd1);

        // Fill to full, drop an extra write, drain in order with no gaps.
        do_reset();
        burst17();
        i_wvalid = 1'b1;
        i_wdata  = 8'hAA;
        tick();
        i_wvalid = 1'b0;
        chk("t3_tx_c16", 32'(o_tx), 32'd0);
        chk("t3_ovf", 32'(o_overflow), 32'd1);
        chk("t3_level_full", 32'(o_level), 32'd16);
        frame(8'h00, 17, FL - 1);
        for (int n = 1; n <= 16; n++)
            frame(8'(n), 0, FL - 1);
        tick();
        chk("t3_busy_done", 32'(o_busy), 32'd0);
        chk("t3_level_done", 32'(o_level), 32'd0);
        chk("t3_tx_idle", 32'(o_tx), 32'd1);
        chk("t3_ovf_sticky", 32'(o_overflow), 32'd1);

        // Write colliding with the frame-boundary pop on a full FIFO is dropped.
        do_reset();
        burst17();
        frame(8'h00, 16, FL - 1);
        i_wvalid = 1'b1;
        i_wdata  = 8'hBB;
        tick();
        i_wvalid = 1'b0;
        chk("t4_ovf", 32'(o_overflow), 32'd1);
        chk("t4_level", 32'(o_level), 32'd15);
        chk("t4_tx_next_start", 32'(o_tx), 32'd0);
        frame(8'h01, 1, FL - 1);

        // Reset during data bit 3 with five bytes queued.
        do_reset();
        for (int n = 0; n < 6; n++) begin
            i_wvalid = 1'b1;
            i_wdata  = (n == 0) ? 8'h00 : 8'(8'h10 * n);
            tick();
        end
        i_wvalid = 1'b0;
        chk("t5_level_q", 32'(o_level), 32'd5);
        frame(8'h00, 5, 17);
        i_rst    = 1'b1;
        i_wvalid = 1'b1;
        i_wdata  = 8'h77;
        tick();
        i_rst    = 1'b0;
        i_wvalid = 1'b0;
        chk("t5_tx", 32'(o_tx), 32'd1);
        chk("t5_level", 32'(o_level), 32'd0);
        chk("t5_busy", 32'(o_busy), 32'd0);
        chk("t5_ovf", 32'(o_overflow), 32'd0);
        tick();
        chk("t5_rst_write_ignored", 32'(o_level), 32'd0);
        chk("t5_tx_idle", 32'(o_tx), 32'd1);
        i_wvalid = 1'b1;
        i_wdata  = 8'h55;
        tick();
        i_wvalid = 1'b0;
        frame(8'h55, 0, FL - 1);
        tick();
        chk("t5_busy_done", 32'(o_busy), 32'd0);

        // Interleaved writes and pops against a cycle-level scoreboard.
        do_reset();
        rem = 0;
        nw  = 0;
        cur = 8'h00;
        for (int cyc = 0; cyc < 36 + 12 * FL + 8; cyc++) begin
            i_wvalid = (cyc % 3 == 0) && (nw < 12);
            i_wdata  = 8'(8'hA5 ^ (nw * 37));
            pop = (rem <= 1) && (q.size() > 0);
            wr  = i_wvalid && (q.size() < DEPTH);
            if (pop) begin
                cur = q.pop_front();
                rem = FL;
            end else if (rem > 0) begin
                rem--;
            end
            if (wr)
                q.push_back(i_wdata);
            if (i_wvalid)
                nw++;
            tick();
            chk($sformatf("t6_level_%0d", cyc), 32'(o_level), 32'(q.size()));
            chk($sformatf("t6_tx_%0d", cyc), 32'(o_tx),
                (rem > 0) ? 32'(exp_bit(cur, (FL - rem) / CPB)) : 32'd1);
        end
        i_wvalid = 1'b0;
        chk("t6_busy_done", 32'(o_busy), 32'd0);
        chk("t6_ovf", 32'(o_overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
